// File: rtl/div28_seq_pkg.sv
// rtl/div28_seq_pkg.sv - shared types and constants for the sequential divider
package div28_seq_pkg;

  localparam int DEF_WIDTH = 27;

  // Quotient reported for a zero divisor; sliced down to the operand width.
  localparam logic [63:0] ZDIV_QUOT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  // One quotient bit per iteration, so WIDTH+1 iterations in total.
  function automatic int iter_count(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/div28_seq_cla.sv
// rtl/div28_seq_cla.sv - cla28 add/subtract adder shared by the divider iterations
module cla28 #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  logic [WIDTH:0] bx;
  logic [WIDTH:0] c;

  // Subtraction is a + ~b + 1; the carry out of the top bit is dropped.
  always_comb begin
    bx   = b ^ {(WIDTH+1){sub}};
    c    = '0;
    c[0] = sub;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = (a[i] & bx[i]) | ((a[i] ^ bx[i]) & c[i]);
    end
    sum = a ^ bx ^ c;
  end

endmodule

// File: rtl/div28_seq.sv
// rtl/div28_seq.sv - sequential unsigned non-restoring divider, one quotient bit per clock
module div28_seq
  import div28_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [WIDTH:0] dividend,
  input  logic [WIDTH:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [WIDTH:0] quotient,
  output logic [WIDTH:0] remainder,
  output logic           div_by_zero
);

  localparam int CNT_W = $clog2(iter_count(WIDTH));
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(iter_count(WIDTH) - 1);

  state_t         state_q, state_d;
  logic [WIDTH:0] q_q, q_d;
  logic [WIDTH:0] d_q, d_d;
  logic [WIDTH+1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           zero_q, zero_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [WIDTH:0] quot_q, quot_d;
  logic [WIDTH:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [WIDTH+1:0] add_a;
  logic [WIDTH+1:0] add_b;
  logic [WIDTH+1:0] add_sum;
  logic             add_sub;

  // R may wrap during the shift; the true result stays in [-D, D) so modulo arithmetic is exact.
  always_comb begin
    add_b = {1'b0, d_q};
    if (state_q == S_FIX) begin
      add_a   = r_q;
      add_sub = 1'b0;
    end else begin
      add_a   = {r_q[WIDTH:0], q_q[WIDTH]};
      add_sub = ~r_q[WIDTH+1];
    end
  end

  cla28 #(
    .WIDTH(WIDTH + 1)
  ) u_add (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        // The done cycle is IDLE too, but a request there waits one more cycle.
        if (start && !done_q) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          zero_d  = (divisor == '0);
          state_d = (divisor == '0) ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        r_d   = add_sum;
        q_d   = {q_q[WIDTH-1:0], ~add_sum[WIDTH+1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (r_q[WIDTH+1]) begin
          r_d = add_sum;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        // With a zero divisor Q still holds the untouched dividend.
        quot_d  = zero_q ? ZDIV_QUOT[WIDTH:0] : q_q;
        rem_d   = zero_q ? q_q : r_q[WIDTH:0];
        dbz_d   = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div28_seq.sv
// tb/tb_div28_seq.sv - directed and randomized self-checking bench for div28_seq
module tb_div28_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [27:0] dividend;
  logic [27:0] divisor;
  logic        busy;
  logic        done;
  logic [27:0] quotient;
  logic [27:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  div28_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int n = 0; n < 100 && (done || busy); n++) @(negedge clk);
  endtask

  // lat = edges from acceptance to the edge after which done is seen (100 = timeout)
  task automatic run_op(input logic [27:0] a, input logic [27:0] b,
                        output int lat, output int bsy);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    bsy   = int'(busy);
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      bsy += int'(busy);
    end
  endtask

  typedef struct {
    logic [27:0] a;
    logic [27:0] b;
    logic [27:0] q;
    logic [27:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, bsy, dn;
    logic [27:0] a, b, eq, er;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    run_op(28'd100, 28'd7, lat, bsy);
    chk("basic_lat", 32'(lat), 32'd30);
    chk("basic_busy_cycles", 32'(bsy), 32'd30);
    chk("basic_q", 32'(quotient), 32'd14);
    chk("basic_r", 32'(remainder), 32'd2);
    chk("basic_dbz", 32'(div_by_zero), 32'd0);

    vecs.push_back('{28'hFFFFFFF, 28'd1,       28'hFFFFFFF, 28'd0,       1'b0, 30});
    vecs.push_back('{28'hFFFFFFF, 28'hFFFFFFF, 28'd1,       28'd0,       1'b0, 30});
    vecs.push_back('{28'hFFFFFFE, 28'hFFFFFFF, 28'd0,       28'hFFFFFFE, 1'b0, 30});
    vecs.push_back('{28'h1234567, 28'd0,       28'hFFFFFFF, 28'h1234567, 1'b1, 1});
    vecs.push_back('{28'd0,       28'd5,       28'd0,       28'd0,       1'b0, 30});
    vecs.push_back('{28'd3,       28'd10,      28'd0,       28'd3,       1'b0, 30});
    vecs.push_back('{28'd1000,    28'd1,       28'd1000,    28'd0,       1'b0, 30});
    vecs.push_back('{28'd255,     28'd16,      28'd15,      28'd15,      1'b0, 30});
    vecs.push_back('{28'h8000000, 28'h0000003, 28'h2AAAAAA, 28'd2,       1'b0, 30});
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, bsy);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_q", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("vec%0d_r", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].z));
    end

    // Handshake: start while busy and on the done cycle.
    wait_idle();
    dividend = 28'd100; divisor = 28'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    dividend = 28'd50; divisor = 28'd5; start = 1'b1;
    @(posedge clk); #1;
    lat++; start = 1'b0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("hs_first_lat", 32'(lat), 32'd30);
    chk("hs_first_q", 32'(quotient), 32'd14);
    chk("hs_first_r", 32'(remainder), 32'd2);
    dividend = 28'd50; divisor = 28'd5; start = 1'b1;
    @(posedge clk); #1;
    chk("hs_done_cycle_rejected", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("hs_accept_next_idle", 32'(busy), 32'd1);
    start = 1'b0; lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (lat == 15) chk("hs_hold_q", 32'(quotient), 32'd14);
    end
    chk("hs_second_lat", 32'(lat), 32'd30);
    chk("hs_second_q", 32'(quotient), 32'd10);
    chk("hs_second_r", 32'(remainder), 32'd0);

    // Reset in the middle of an operation.
    wait_idle();
    dividend = 28'd100; divisor = 28'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_quot", 32'(quotient), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    dn = 0;
    repeat (3) begin @(negedge clk); dn += int'(done); end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); dn += int'(done); end
    chk("mid_rst_no_done", 32'(dn), 32'd0);
    run_op(28'd9, 28'd4, lat, bsy);
    chk("post_rst_lat", 32'(lat), 32'd30);
    chk("post_rst_q", 32'(quotient), 32'd2);
    chk("post_rst_r", 32'(remainder), 32'd1);

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 200; i++) begin
      a = 28'($urandom);
      case ($urandom_range(0, 19))
        0:       b = '0;
        1, 2, 3: b = 28'($urandom_range(1, 1000));
        4:       b = 28'd1;
        default: b = 28'($urandom);
      endcase
      if (b == '0) begin
        eq = 28'hFFFFFFF; er = a;
      end else begin
        eq = a / b; er = a % b;
      end
      run_op(a, b, lat, bsy);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), (b == '0) ? 32'd1 : 32'd30);
      chk($sformatf("rnd%0d_q", i), 32'(quotient), 32'(eq));
      chk($sformatf("rnd%0d_r", i), 32'(remainder), 32'(er));
      chk($sformatf("rnd%0d_dbz", i), 32'(div_by_zero), 32'(b == '0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
